alu_result_pipeline: RTL and testbench
======================================

Name: alu_result_pipeline

Overview:
- Sits directly downstream of the single-cycle integer ALU lanes in the execute stage.
- Delays each single-cycle lane result by LATENCY cycles so it reaches writeback in step with the multi-cycle (FP/multiply) pipeline.
- Selects between the delayed single-cycle result and the multi-cycle result.
- Applies per-thread rollback squash and a global stall.
- Presents one registered writeback request per cycle.

Parameters:
- LANES, 16, number of 32-bit vector lanes carried per instruction.
- LATENCY, 4, pipeline depth in cycles; must equal the multi-cycle ALU depth; legal range 2..8.
- THREADS, 4, hardware thread count; thread id width is clog2(THREADS).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising clk.
- stall  in  1  freeze all slots; no advance, no output change.
- rollback_en  in  1  squash request.
- rollback_thread  in  TID_W  thread to squash.
- ex_valid  in  1  new instruction entering this cycle.
- ex_thread  in  TID_W  issuing thread.
- ex_is_multi  in  1  1 = result comes from the multi-cycle pipeline.
- ex_wb_reg  in  5  destination register index.
- ex_is_vector  in  1  1 = vector destination.
- ex_mask  in  LANES  lane write-enable mask.
- ex_single_result  in  32*LANES  unregistered single-cycle ALU lane results; lane n is bits [32n+31:32n].
- mc_result  in  32*LANES  multi-cycle result, aligned with the oldest slot.
- wb_valid  out  1  writeback request.
- wb_thread  out  TID_W  thread of the writeback.
- wb_reg  out  5  destination register.
- wb_is_vector  out  1  vector destination flag.
- wb_mask  out  LANES  lane write-enable mask.
- wb_result  out  32*LANES  selected result.

Behaviour:
- Reset: while reset==0 at a clock edge:
  - all slot valid bits clear;
  - wb_valid=0, wb_thread=0, wb_reg=0, wb_is_vector=0, wb_mask=0, wb_result=0.
  - Reset overrides stall and rollback.
  - A reset mid-flight discards all in-flight entries; nothing is written back afterwards.
- Slots: LATENCY-1 internal slots S1..S(LATENCY-1), plus the output register.
  - Each slot holds valid, thread, is_multi, wb_reg, is_vector, mask, and result (result only when is_multi=0).
- Advance (stall=0):
  - S1 <= ex_* with ex_single_result.
  - Sk <= S(k-1).
  - Output register <= S(LATENCY-1).
  - Output result is mc_result if S(LATENCY-1).is_multi, else S(LATENCY-1).result.
  - Latency from ex_valid to wb_valid is exactly LATENCY cycles.
- Stall (stall=1):
  - all slots and outputs hold;
  - ex_valid is ignored (the issuer must not issue while stalled);
  - wb_valid is held, but the consumer treats output as not new while stalled.
- Rollback:
  - rollback_en=1 clears the valid bit of every slot and of the incoming ex entry whose thread==rollback_thread.
  - This applies in the same cycle, whether or not stall is asserted.
  - The output register is NOT squashed; it already committed.
  - Entries of other threads are unaffected.
- Simultaneous rollback and advance: the squash is applied to the values being shifted.
  - A matching entry moving S1->S2 arrives invalid.
- Invalid slot: payload fields are don't-care.
  - wb_valid=0 whenever the output slot is invalid; other wb_* fields are unchanged in that case.
- Multi-cycle result selection: mc_result is sampled only on the advance edge when S(LATENCY-1) is valid and is_multi=1.
- Output register always updates on advance (no bubble collapse); throughput is one instruction per cycle.
- Masks and register indices pass through unmodified; no lane-wise gating of the result data.

Decomposition:
- Shared defines package:
  - TID_W derived from THREADS;
  - the writeback register index width (5);
  - the lane data width (32).
- One natural sub-module: alu_result_slot, a single pipeline register stage with stall hold and thread-match squash.
  - It is instantiated LATENCY-1 times via generate.
  - The top level adds the final result mux and output register.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles with ex_valid=1 -> after reset=1, wb_valid=0 until 4 cycles after the first new issue; all wb_* fields are 0 during reset.
- Back-to-back singles: issue thread 0 to r3 with lane0=0x12345678, then thread 1 to r4 with lane0=0xDEADBEEF on consecutive cycles -> wb_valid on cycles +4 and +5 with matching thread, reg and data.
- Multi-cycle select: issue with ex_is_multi=1, drive mc_result lane0=0x3F800000 in the cycle before output -> wb_result lane0=0x3F800000, and ex_single_result is ignored.
- Stall: issue at t0, stall for t1..t3 -> wb_valid rises at t0+7; the output holds its value across every stalled cycle.
- Rollback: issue threads 2,1,2,3 in consecutive cycles, then rollback_en with rollback_thread=2 while all four are in flight -> only the thread 1 and thread 3 writebacks appear, 2 cycles apart.
- Rollback with incoming issue: rollback thread 0 in the same cycle as ex_valid for thread 0 -> no writeback for it; a thread 1 issue in the next cycle writes back normally.

Source files
------------

// File: rtl/alu_result_pipeline_pkg.sv
// -----------------------------------------------------------------------------
// alu_result_pipeline_pkg
// Shared definitions for the single-cycle ALU result delay pipeline.
//   REG_W     : width of a writeback register index
//   DATA_W    : width of one vector lane
//   tidWidth(): thread-id width for a given hardware thread count
// -----------------------------------------------------------------------------
package alu_result_pipeline_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    // A single-thread core still carries a 1-bit thread id so port widths
    // never collapse to zero.
    function automatic int tidWidth(input int threads);
        return (threads > 1) ? $clog2(threads) : 1;
    endfunction

endpackage

// File: rtl/alu_result_slot.sv
// -----------------------------------------------------------------------------
// alu_result_slot
// One stage of the result delay pipeline. Captures the upstream entry on
// every non-stalled edge, holds while stalled, and drops the valid bit of any
// entry belonging to the thread being rolled back.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   stall                 : hold current contents
//   rollback_en/_thread   : squash request and the thread to squash
//   *_i                   : upstream entry (valid + payload)
//   *_o                   : this stage's registered entry
// -----------------------------------------------------------------------------
module alu_result_slot
    import alu_result_pipeline_pkg::*;
#(
    parameter int LANES = 16,
    parameter int TID_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    rollback_en,
    input  logic [TID_W-1:0]        rollback_thread,
    input  logic                    valid_i,
    input  logic [TID_W-1:0]        thread_i,
    input  logic                    isMulti_i,
    input  logic [REG_W-1:0]        wbReg_i,
    input  logic                    isVector_i,
    input  logic [LANES-1:0]        mask_i,
    input  logic [DATA_W*LANES-1:0] result_i,
    output logic                    valid_o,
    output logic [TID_W-1:0]        thread_o,
    output logic                    isMulti_o,
    output logic [REG_W-1:0]        wbReg_o,
    output logic                    isVector_o,
    output logic [LANES-1:0]        mask_o,
    output logic [DATA_W*LANES-1:0] result_o
);

    logic                    valid_q,    valid_d;
    logic [TID_W-1:0]        thread_q,   thread_d;
    logic                    isMulti_q,  isMulti_d;
    logic [REG_W-1:0]        wbReg_q,    wbReg_d;
    logic                    isVector_q, isVector_d;
    logic [LANES-1:0]        mask_q,     mask_d;
    logic [DATA_W*LANES-1:0] result_q,   result_d;
    logic                    squashIn;
    logic                    squashHeld;

    // Next-state: hold (squashing our own entry) when stalled, otherwise
    // take the upstream entry with the squash applied to it in flight.
    // The lane data is only worth capturing for single-cycle results; the
    // multi-cycle result arrives separately at the end of the pipe.
    always_comb begin
        squashIn   = rollback_en && (thread_i == rollback_thread);
        squashHeld = rollback_en && (thread_q == rollback_thread);
        valid_d    = valid_q && !squashHeld;
        thread_d   = thread_q;
        isMulti_d  = isMulti_q;
        wbReg_d    = wbReg_q;
        isVector_d = isVector_q;
        mask_d     = mask_q;
        result_d   = result_q;
        if (!stall) begin
            valid_d    = valid_i && !squashIn;
            thread_d   = thread_i;
            isMulti_d  = isMulti_i;
            wbReg_d    = wbReg_i;
            isVector_d = isVector_i;
            mask_d     = mask_i;
            if (!isMulti_i) begin
                result_d = result_i;
            end
        end
    end

    // Only the valid bit needs reset; payload is don't-care when invalid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload registers follow the next-state logic unconditionally.
    always_ff @(posedge clk) begin
        thread_q   <= thread_d;
        isMulti_q  <= isMulti_d;
        wbReg_q    <= wbReg_d;
        isVector_q <= isVector_d;
        mask_q     <= mask_d;
        result_q   <= result_d;
    end

    assign valid_o    = valid_q;
    assign thread_o   = thread_q;
    assign isMulti_o  = isMulti_q;
    assign wbReg_o    = wbReg_q;
    assign isVector_o = isVector_q;
    assign mask_o     = mask_q;
    assign result_o   = result_q;

endmodule

// File: rtl/alu_result_pipeline.sv
// -----------------------------------------------------------------------------
// alu_result_pipeline
// Delays single-cycle ALU lane results by LATENCY cycles so they reach
// writeback in step with the multi-cycle pipeline, selects between the two
// result sources, and presents one registered writeback request per cycle.
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   stall                : freeze every stage and the output
//   rollback_en/_thread  : squash all in-flight entries of one thread
//   ex_*                 : instruction entering from execute
//   mc_result            : multi-cycle result aligned with the oldest slot
//   wb_*                 : registered writeback request
// LATENCY must match the multi-cycle ALU depth (2..8).
// -----------------------------------------------------------------------------
module alu_result_pipeline
    import alu_result_pipeline_pkg::*;
#(
    parameter int LANES   = 16,
    parameter int LATENCY = 4,
    parameter int THREADS = 4,
    localparam int TID_W  = tidWidth(THREADS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic                    rollback_en,
    input  logic [TID_W-1:0]        rollback_thread,
    input  logic                    ex_valid,
    input  logic [TID_W-1:0]        ex_thread,
    input  logic                    ex_is_multi,
    input  logic [REG_W-1:0]        ex_wb_reg,
    input  logic                    ex_is_vector,
    input  logic [LANES-1:0]        ex_mask,
    input  logic [DATA_W*LANES-1:0] ex_single_result,
    input  logic [DATA_W*LANES-1:0] mc_result,
    output logic                    wb_valid,
    output logic [TID_W-1:0]        wb_thread,
    output logic [REG_W-1:0]        wb_reg,
    output logic                    wb_is_vector,
    output logic [LANES-1:0]        wb_mask,
    output logic [DATA_W*LANES-1:0] wb_result
);

    localparam int LAST = LATENCY - 1;

    // Index 0 is the incoming execute entry, index k is slot Sk.
    logic                    chainValid    [LATENCY];
    logic [TID_W-1:0]        chainThread   [LATENCY];
    logic                    chainMulti    [LATENCY];
    logic [REG_W-1:0]        chainReg      [LATENCY];
    logic                    chainVector   [LATENCY];
    logic [LANES-1:0]        chainMask     [LATENCY];
    logic [DATA_W*LANES-1:0] chainResult   [LATENCY];

    logic                    wbValid_q,    wbValid_d;
    logic [TID_W-1:0]        wbThread_q,   wbThread_d;
    logic [REG_W-1:0]        wbReg_q,      wbReg_d;
    logic                    wbIsVector_q, wbIsVector_d;
    logic [LANES-1:0]        wbMask_q,     wbMask_d;
    logic [DATA_W*LANES-1:0] wbResult_q,   wbResult_d;
    logic                    lastLive;

    assign chainValid[0]  = ex_valid;
    assign chainThread[0] = ex_thread;
    assign chainMulti[0]  = ex_is_multi;
    assign chainReg[0]    = ex_wb_reg;
    assign chainVector[0] = ex_is_vector;
    assign chainMask[0]   = ex_mask;
    assign chainResult[0] = ex_single_result;

    // Stages S1..S(LATENCY-1), each fed by its predecessor.
    for (genvar k = 1; k < LATENCY; k++) begin : gSlot
        alu_result_slot #(
            .LANES (LANES),
            .TID_W (TID_W)
        ) uSlot (
            .clk             (clk),
            .reset           (reset),
            .stall           (stall),
            .rollback_en     (rollback_en),
            .rollback_thread (rollback_thread),
            .valid_i         (chainValid[k-1]),
            .thread_i        (chainThread[k-1]),
            .isMulti_i       (chainMulti[k-1]),
            .wbReg_i         (chainReg[k-1]),
            .isVector_i      (chainVector[k-1]),
            .mask_i          (chainMask[k-1]),
            .result_i        (chainResult[k-1]),
            .valid_o         (chainValid[k]),
            .thread_o        (chainThread[k]),
            .isMulti_o       (chainMulti[k]),
            .wbReg_o         (chainReg[k]),
            .isVector_o      (chainVector[k]),
            .mask_o          (chainMask[k]),
            .result_o        (chainResult[k])
        );
    end

    // Output stage. The entry leaving the last slot is still in flight, so
    // a rollback of its thread squashes it on the way into the output
    // register; what is already in the output register has committed.
    // An invalid entry only clears wb_valid and leaves the payload alone,
    // and mc_result is only sampled when a live multi-cycle entry leaves.
    always_comb begin
        lastLive     = chainValid[LAST] &&
                       !(rollback_en && (chainThread[LAST] == rollback_thread));
        wbValid_d    = wbValid_q;
        wbThread_d   = wbThread_q;
        wbReg_d      = wbReg_q;
        wbIsVector_d = wbIsVector_q;
        wbMask_d     = wbMask_q;
        wbResult_d   = wbResult_q;
        if (!stall) begin
            wbValid_d = lastLive;
            if (lastLive) begin
                wbThread_d   = chainThread[LAST];
                wbReg_d      = chainReg[LAST];
                wbIsVector_d = chainVector[LAST];
                wbMask_d     = chainMask[LAST];
                wbResult_d   = chainMulti[LAST] ? mc_result : chainResult[LAST];
            end
        end
    end

    // Writeback register; reset clears everything regardless of stall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wbValid_q    <= 1'b0;
            wbThread_q   <= '0;
            wbReg_q      <= '0;
            wbIsVector_q <= 1'b0;
            wbMask_q     <= '0;
            wbResult_q   <= '0;
        end else begin
            wbValid_q    <= wbValid_d;
            wbThread_q   <= wbThread_d;
            wbReg_q      <= wbReg_d;
            wbIsVector_q <= wbIsVector_d;
            wbMask_q     <= wbMask_d;
            wbResult_q   <= wbResult_d;
        end
    end

    assign wb_valid     = wbValid_q;
    assign wb_thread    = wbThread_q;
    assign wb_reg       = wbReg_q;
    assign wb_is_vector = wbIsVector_q;
    assign wb_mask      = wbMask_q;
    assign wb_result    = wbResult_q;

endmodule

// File: tb/tb_alu_result_pipeline.sv
// -----------------------------------------------------------------------------
// tb_alu_result_pipeline
// Directed bench for alu_result_pipeline. Each issued instruction that should
// write back pushes its expected fields and the clock edge it must appear on
// into a queue; a monitor pops and compares on every advancing edge.
// -----------------------------------------------------------------------------
module tb_alu_result_pipeline;

    localparam int LANES   = 16;
    localparam int LATENCY = 4;
    localparam int THREADS = 4;
    localparam int TID_W   = 2;
    localparam int W       = 32 * LANES;

    typedef struct {
        logic [TID_W-1:0] thread;
        logic [4:0]       wbReg;
        logic             isVector;
        logic [LANES-1:0] mask;
        logic [W-1:0]     result;
        int               dueEdge;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             stall;
    logic             rollback_en;
    logic [TID_W-1:0] rollback_thread;
    logic             ex_valid;
    logic [TID_W-1:0] ex_thread;
    logic             ex_is_multi;
    logic [4:0]       ex_wb_reg;
    logic             ex_is_vector;
    logic [LANES-1:0] ex_mask;
    logic [W-1:0]     ex_single_result;
    logic [W-1:0]     mc_result;
    logic             wb_valid;
    logic [TID_W-1:0] wb_thread;
    logic [4:0]       wb_reg;
    logic             wb_is_vector;
    logic [LANES-1:0] wb_mask;
    logic [W-1:0]     wb_result;

    exp_t expQ[$];
    exp_t monEntry;
    int   compared   = 0;
    int   mismatched = 0;
    int   edgeNum    = 0;
    bit   advanced   = 1'b0;

    alu_result_pipeline #(
        .LANES   (LANES),
        .LATENCY (LATENCY),
        .THREADS (THREADS)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .rollback_en      (rollback_en),
        .rollback_thread  (rollback_thread),
        .ex_valid         (ex_valid),
        .ex_thread        (ex_thread),
        .ex_is_multi      (ex_is_multi),
        .ex_wb_reg        (ex_wb_reg),
        .ex_is_vector     (ex_is_vector),
        .ex_mask          (ex_mask),
        .ex_single_result (ex_single_result),
        .mc_result        (mc_result),
        .wb_valid         (wb_valid),
        .wb_thread        (wb_thread),
        .wb_reg           (wb_reg),
        .wb_is_vector     (wb_is_vector),
        .wb_mask          (wb_mask),
        .wb_result        (wb_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane n carries lane0 with n folded into the top byte.
    function automatic logic [W-1:0] makeVec(input logic [31:0] lane0);
        logic [W-1:0] v;
        for (int n = 0; n < LANES; n++) begin
            v[32*n +: 32] = lane0 ^ (32'(n) << 24);
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one issue for the next edge; pushes the expected writeback when
    // the entry should survive. extraDelay counts stalled edges in flight.
    task automatic applyStimulus(input logic [TID_W-1:0] thread, input logic [4:0] wbReg,
                                 input logic isMulti, input logic isVector,
                                 input logic [LANES-1:0] mask, input logic [W-1:0] single,
                                 input bit expectWb, input logic [W-1:0] expResult,
                                 input int extraDelay);
        exp_t e;
        ex_valid         = 1'b1;
        ex_thread        = thread;
        ex_wb_reg        = wbReg;
        ex_is_multi      = isMulti;
        ex_is_vector     = isVector;
        ex_mask          = mask;
        ex_single_result = single;
        if (expectWb) begin
            e.thread   = thread;
            e.wbReg    = wbReg;
            e.isVector = isVector;
            e.mask     = mask;
            e.result   = expResult;
            e.dueEdge  = edgeNum + LATENCY + extraDelay;
            expQ.push_back(e);
        end
        tick();
        ex_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Edge bookkeeping: an edge advances the pipe only out of reset and
    // without stall.
    always @(posedge clk) begin
        edgeNum++;
        advanced = (reset === 1'b1) && (stall === 1'b0);
    end

    // Monitor: every advancing edge that presents wb_valid must match the
    // oldest expectation; an expectation whose edge has passed is missing.
    always @(negedge clk) begin
        if (advanced && wb_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_wb", W'(wb_valid), W'(0));
            end else begin
                monEntry = expQ.pop_front();
                checkOutput("wb_edge",      W'(edgeNum),      W'(monEntry.dueEdge));
                checkOutput("wb_thread",    W'(wb_thread),    W'(monEntry.thread));
                checkOutput("wb_reg",       W'(wb_reg),       W'(monEntry.wbReg));
                checkOutput("wb_is_vector", W'(wb_is_vector), W'(monEntry.isVector));
                checkOutput("wb_mask",      W'(wb_mask),      W'(monEntry.mask));
                checkOutput("wb_result",    wb_result,        monEntry.result);
            end
        end else if (expQ.size() > 0 && expQ[0].dueEdge <= edgeNum) begin
            monEntry = expQ.pop_front();
            checkOutput("wb_missing", W'(0), W'(1));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset            = 1'b0;
        stall            = 1'b1;
        rollback_en      = 1'b1;
        rollback_thread  = 2'd1;
        ex_valid         = 1'b1;
        ex_thread        = 2'd1;
        ex_is_multi      = 1'b0;
        ex_wb_reg        = 5'd17;
        ex_is_vector     = 1'b1;
        ex_mask          = 16'hFFFF;
        ex_single_result = makeVec(32'hCAFEF00D);
        mc_result        = makeVec(32'h0BADF00D);

        // Reset beats stall, rollback and a live issue.
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("rst_wb_valid",  W'(wb_valid),     W'(0));
            checkOutput("rst_wb_thread", W'(wb_thread),    W'(0));
            checkOutput("rst_wb_reg",    W'(wb_reg),       W'(0));
            checkOutput("rst_wb_vector", W'(wb_is_vector), W'(0));
            checkOutput("rst_wb_mask",   W'(wb_mask),      W'(0));
            checkOutput("rst_wb_result", wb_result,        W'(0));
        end
        stall       = 1'b0;
        rollback_en = 1'b0;
        ex_valid    = 1'b0;
        reset       = 1'b1;
        idle(4);

        // Back-to-back singles.
        applyStimulus(2'd0, 5'd3, 1'b0, 1'b0, 16'h0001, makeVec(32'h12345678),
                      1'b1, makeVec(32'h12345678), 0);
        applyStimulus(2'd1, 5'd4, 1'b0, 1'b1, 16'hF0F0, makeVec(32'hDEADBEEF),
                      1'b1, makeVec(32'hDEADBEEF), 0);
        idle(6);
        // Invalid output slot leaves the payload where it was.
        checkOutput("idle_wb_valid",  W'(wb_valid), W'(0));
        checkOutput("idle_wb_reg",    W'(wb_reg),   W'(4));
        checkOutput("idle_wb_result", wb_result,    makeVec(32'hDEADBEEF));

        // Multi-cycle select: mc_result only counts in the cycle before output.
        mc_result = makeVec(32'hBAD0BAD0);
        applyStimulus(2'd2, 5'd7, 1'b1, 1'b1, 16'hFFFF, makeVec(32'h11111111),
                      1'b1, makeVec(32'h3F800000), 0);
        idle(LATENCY - 2);
        mc_result = makeVec(32'h3F800000);
        tick();
        mc_result = makeVec(32'h55AA55AA);
        idle(4);

        // Stall: P reaches the output as Q issues, then three stalled edges
        // with junk on ex_valid; the output must keep showing P.
        applyStimulus(2'd3, 5'd9, 1'b0, 1'b0, 16'h00FF, makeVec(32'hA5A5A5A5),
                      1'b1, makeVec(32'hA5A5A5A5), 0);
        idle(LATENCY - 2);
        applyStimulus(2'd0, 5'd10, 1'b0, 1'b1, 16'h0F0F, makeVec(32'h0C0FFEE0),
                      1'b1, makeVec(32'h0C0FFEE0), 3);
        stall            = 1'b1;
        ex_valid         = 1'b1;
        ex_thread        = 2'd1;
        ex_wb_reg        = 5'd31;
        ex_single_result = makeVec(32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_wb_valid",  W'(wb_valid),  W'(1));
            checkOutput("stall_wb_thread", W'(wb_thread), W'(3));
            checkOutput("stall_wb_reg",    W'(wb_reg),    W'(9));
            checkOutput("stall_wb_result", wb_result,     makeVec(32'hA5A5A5A5));
        end
        ex_valid = 1'b0;
        stall    = 1'b0;
        idle(6);

        // Rollback while stalled squashes the held entry.
        applyStimulus(2'd3, 5'd12, 1'b0, 1'b0, 16'h0001, makeVec(32'h13579BDF),
                      1'b0, W'(0), 0);
        stall           = 1'b1;
        rollback_en     = 1'b1;
        rollback_thread = 2'd3;
        tick();
        rollback_en     = 1'b0;
        tick();
        stall           = 1'b0;
        idle(6);

        // Rollback of thread 2 with four entries in flight.
        applyStimulus(2'd2, 5'd1, 1'b0, 1'b0, 16'h0003, makeVec(32'h22222222),
                      1'b0, W'(0), 0);
        applyStimulus(2'd1, 5'd2, 1'b0, 1'b1, 16'h0005, makeVec(32'h11110001),
                      1'b1, makeVec(32'h11110001), 0);
        applyStimulus(2'd2, 5'd5, 1'b0, 1'b0, 16'h0009, makeVec(32'h22220002),
                      1'b0, W'(0), 0);
        rollback_en     = 1'b1;
        rollback_thread = 2'd2;
        applyStimulus(2'd3, 5'd6, 1'b0, 1'b1, 16'h0011, makeVec(32'h33330003),
                      1'b1, makeVec(32'h33330003), 0);
        rollback_en     = 1'b0;
        idle(6);

        // Rollback hits the incoming issue; the next thread is untouched.
        rollback_en     = 1'b1;
        rollback_thread = 2'd0;
        applyStimulus(2'd0, 5'd8, 1'b0, 1'b0, 16'h0101, makeVec(32'h00000BAD),
                      1'b0, W'(0), 0);
        rollback_en     = 1'b0;
        applyStimulus(2'd1, 5'd11, 1'b0, 1'b0, 16'h8001, makeVec(32'h600D600D),
                      1'b1, makeVec(32'h600D600D), 0);
        idle(6);

        // Reset mid-flight discards the in-flight entry.
        applyStimulus(2'd2, 5'd13, 1'b0, 1'b0, 16'h0002, makeVec(32'h7777AAAA),
                      1'b0, W'(0), 0);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        idle(6);

        checkOutput("queue_drained", W'(expQ.size()), W'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
